// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO.
// Configurable width/depth, standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count and
// sticky overrun/underrun error flags with a software clear.
// Status flags decode the registered count only, so they carry no
// combinational path from we/re.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit FWFT       = 1'b0,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] r_data,
  input  logic [CW-1:0]         af_level,
  input  logic [CW-1:0]         ae_level,
  input  logic                  clr_err,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overrun,
  output logic                  underrun
);

  // Storage is left uninitialised on reset; only the pointers are cleared.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;

  logic          rd_acc;
  logic          wr_acc;

  // Status decodes from the registered occupancy.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= af_level);
  assign almost_empty = (count_q <= ae_level);
  assign overrun      = overrun_q;
  assign underrun     = underrun_q;

  // Acceptance: a write into a full FIFO is only taken when a read frees a slot
  // in the same cycle; a read of an empty FIFO is always rejected.
  always_comb begin
    rd_acc = re & ~empty;
    wr_acc = we & (~full | rd_acc);
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (wr_acc) begin
      wp_d = wp_q + AW'(1);
    end
    if (rd_acc) begin
      rp_d = rp_q + AW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky error flags: a new error in the clearing cycle takes precedence.
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (clr_err) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (we & ~wr_acc) begin
      overrun_d = 1'b1;
    end
    if (re & ~rd_acc) begin
      underrun_d = 1'b1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Memory write port; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wp_q] <= w_data;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented continuously; re acknowledges it.
      assign r_data = mem_q[rp_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data_q;

      // Registered read: load the head word on an accepted read, hold otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data_q <= '0;
        end else if (rd_acc) begin
          r_data_q <= mem_q[rp_q];
        end
      end

      assign r_data = r_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: a standard-mode and an FWFT instance share
// all inputs; a queue-based model of the FIFO supplies expected values.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          we = 1'b0, re = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [CW-1:0] af_level = 4'd6, ae_level = 4'd1;

  logic [DW-1:0] s_rdata, f_rdata;
  logic [CW-1:0] s_count, f_count;
  logic s_full, s_empty, s_af, s_ae, s_ovr, s_udr;
  logic f_full, f_empty, f_af, f_ae, f_ovr, f_udr;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .we(we), .w_data(w_data), .re(re), .r_data(s_rdata),
    .af_level(af_level), .ae_level(ae_level), .clr_err(clr_err), .count(s_count),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .overrun(s_ovr), .underrun(s_udr));

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut_fw (
    .clk(clk), .rst(rst), .we(we), .w_data(w_data), .re(re), .r_data(f_rdata),
    .af_level(af_level), .ae_level(ae_level), .clr_err(clr_err), .count(f_count),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .overrun(f_ovr), .underrun(f_udr));

  // Reference model: contents as a queue, registered read value, error flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata = '0;
  bit            m_ovr = 1'b0, m_udr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Apply current inputs to the model, then advance one clock edge.
  task automatic tick();
    bit rd, wr;
    if (rst) begin
      mq.delete();
      m_rdata = '0;
      m_ovr   = 1'b0;
      m_udr   = 1'b0;
    end else begin
      rd = re && (mq.size() > 0);
      wr = we && ((mq.size() < DEPTH) || rd);
      if (rd) m_rdata = mq.pop_front();
      if (wr) mq.push_back(w_data);
      if (we && !wr) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
      if (re && !rd) m_udr = 1'b1;
      else if (clr_err) m_udr = 1'b0;
    end
    $display("txn %0d: rst=%0b we=%0b wd=%h re=%0b clr=%0b model_count=%0d",
             cyc, rst, we, w_data, re, clr_err, mq.size());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; clr_err = 1'b0;
    af_level = 4'd6; ae_level = 4'd1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if ({s_count, s_full, s_empty, s_af, s_ae, s_ovr, s_udr} !== {4'd0, 6'b010100}) begin
      n_fail++; $display("FAIL reset_status: got cnt=%0d full=%b empty=%b af=%b ae=%b ovr=%b udr=%b want cnt=0 full=0 empty=1 af=0 ae=1 ovr=0 udr=0",
                         s_count, s_full, s_empty, s_af, s_ae, s_ovr, s_udr); end
    n_checks++; if (s_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", s_rdata); end
    n_checks++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL reset_fwft_empty: got %b want 1", f_empty); end
  endtask

  task automatic test_fill_order();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; w_data = 8'((i + 1) * 17);
      tick();
      n_checks++; if (s_count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", s_count, i + 1); end
      n_checks++; if (s_af !== (i + 1 >= 6)) begin n_fail++; $display("FAIL fill_af: got %b want %b after write %0d", s_af, (i + 1 >= 6), i + 1); end
      n_checks++; if (s_full !== (i == 7)) begin n_fail++; $display("FAIL fill_full: got %b want %b after write %0d", s_full, (i == 7), i + 1); end
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      re = 1'b1;
      tick();
      n_checks++; if (s_rdata !== 8'((i + 1) * 17)) begin n_fail++; $display("FAIL order_rdata: got %h want %h", s_rdata, 8'((i + 1) * 17)); end
      n_checks++; if (s_ae !== (7 - i <= 1)) begin n_fail++; $display("FAIL order_ae: got %b want %b at count %0d", s_ae, (7 - i <= 1), 7 - i); end
      n_checks++; if (s_empty !== (i == 7)) begin n_fail++; $display("FAIL order_empty: got %b want %b", s_empty, (i == 7)); end
    end
    idle();
  endtask

  task automatic test_overrun_wrap();
    logic [DW-1:0] exp_rd [8];
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; w_data = 8'(8'h10 + i); tick();
    end
    w_data = 8'hAA; tick();
    n_checks++; if (s_ovr !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", s_ovr); end
    n_checks++; if (s_count !== 4'd8) begin n_fail++; $display("FAIL overrun_count: got %0d want 8", s_count); end
    we = 1'b0; clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_checks++; if (s_ovr !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", s_ovr); end
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; tick();
      n_checks++; if (s_rdata !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL wrap_read_a: got %h want %h", s_rdata, 8'(8'h10 + i)); end
    end
    re = 1'b0;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; w_data = 8'(8'h20 + i); tick();
    end
    we = 1'b0;
    for (int i = 0; i < 4; i++) exp_rd[i] = 8'(8'h14 + i);
    for (int i = 0; i < 4; i++) exp_rd[i + 4] = 8'(8'h20 + i);
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; tick();
      n_checks++; if (s_rdata !== exp_rd[i]) begin n_fail++; $display("FAIL wrap_read_b: got %h want %h", s_rdata, exp_rd[i]); end
    end
    idle();
    n_checks++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", s_empty); end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 3; i++) begin
      re = 1'b1; tick();
    end
    n_checks++; if (s_udr !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b want 1", s_udr); end
    n_checks++; if (s_count !== 4'd0) begin n_fail++; $display("FAIL underrun_count: got %0d want 0", s_count); end
    n_checks++; if (s_rdata !== 8'h23) begin n_fail++; $display("FAIL underrun_rdata: got %h want 23", s_rdata); end
    we = 1'b1; w_data = 8'h5C; tick(); we = 1'b0;
    n_checks++; if (s_count !== 4'd1) begin n_fail++; $display("FAIL underrun_wr_count: got %0d want 1", s_count); end
    n_checks++; if (s_udr !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", s_udr); end
    clr_err = 1'b1; tick(); clr_err = 1'b0; re = 1'b0;
    n_checks++; if ({s_udr, s_rdata, s_count} !== {1'b0, 8'h5C, 4'd0}) begin
      n_fail++; $display("FAIL underrun_clear_read: got udr=%b rd=%h cnt=%0d want udr=0 rd=5c cnt=0", s_udr, s_rdata, s_count); end
    idle();
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; w_data = 8'(8'h30 + i); tick();
    end
    re = 1'b1; w_data = 8'hE1; tick(); we = 1'b0;
    n_checks++; if ({s_count, s_ovr, s_rdata} !== {4'd8, 1'b0, 8'h30}) begin
      n_fail++; $display("FAIL full_simul: got cnt=%0d ovr=%b rd=%h want cnt=8 ovr=0 rd=30", s_count, s_ovr, s_rdata); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++; if (s_rdata !== ((i == 7) ? 8'hE1 : 8'(8'h31 + i))) begin
        n_fail++; $display("FAIL full_simul_read: got %h want %h", s_rdata, ((i == 7) ? 8'hE1 : 8'(8'h31 + i))); end
    end
    idle();
  endtask

  task automatic test_threshold_comb();
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; w_data = 8'(8'h40 + i); tick();
    end
    we = 1'b0;
    af_level = 4'd3; #1;
    n_checks++; if (s_af !== 1'b1) begin n_fail++; $display("FAIL thr_af_eq: got %b want 1", s_af); end
    af_level = 4'd4; #1;
    n_checks++; if (s_af !== 1'b0) begin n_fail++; $display("FAIL thr_af_above: got %b want 0", s_af); end
    ae_level = 4'd3; #1;
    n_checks++; if (s_ae !== 1'b1) begin n_fail++; $display("FAIL thr_ae_eq: got %b want 1", s_ae); end
    ae_level = 4'd2; #1;
    n_checks++; if (s_ae !== 1'b0) begin n_fail++; $display("FAIL thr_ae_below: got %b want 0", s_ae); end
    af_level = 4'd6; ae_level = 4'd1;
    re = 1'b1; tick(); tick(); tick();
    idle();
  endtask

  task automatic test_fwft();
    we = 1'b1; w_data = 8'h3C; tick(); we = 1'b0;
    n_checks++; if ({f_empty, f_rdata} !== {1'b0, 8'h3C}) begin
      n_fail++; $display("FAIL fwft_first: got empty=%b rd=%h want empty=0 rd=3c", f_empty, f_rdata); end
    re = 1'b1; tick(); re = 1'b0;
    n_checks++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty: got %b want 1", f_empty); end
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; w_data = 8'(8'h50 + i); tick();
      n_checks++; if (f_rdata !== 8'h50) begin n_fail++; $display("FAIL fwft_head: got %h want 50", f_rdata); end
    end
    we = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if ({f_count, f_empty, s_empty, s_rdata} !== {4'd0, 1'b1, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL fwft_reset: got cnt=%0d fempty=%b sempty=%b srd=%h want 0 1 1 00", f_count, f_empty, s_empty, s_rdata); end
    we = 1'b1; w_data = 8'h77; tick(); we = 1'b0;
    n_checks++; if (f_rdata !== 8'h77) begin n_fail++; $display("FAIL fwft_after_reset: got %h want 77", f_rdata); end
    re = 1'b1; tick();
    idle();
  endtask

  task automatic test_random();
    logic [9:0] exp_st, got_st;
    int wprob = 50;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) wprob = $urandom_range(15, 85);
      if (n % 32 == 0) begin
        af_level = 4'($urandom_range(0, 8));
        ae_level = 4'($urandom_range(0, 8));
      end
      we      = ($urandom_range(0, 99) < wprob);
      re      = ($urandom_range(0, 99) >= wprob - 10);
      w_data  = 8'($urandom);
      clr_err = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      tick();
      exp_st = {4'(mq.size()), (mq.size() == DEPTH), (mq.size() == 0),
                (mq.size() >= int'(af_level)), (mq.size() <= int'(ae_level)), m_ovr, m_udr};
      got_st = {s_count, s_full, s_empty, s_af, s_ae, s_ovr, s_udr};
      n_checks++; if (got_st !== exp_st) begin n_fail++; $display("FAIL rand_status cyc %0d: got %b want %b", cyc, got_st, exp_st); end
      n_checks++; if (s_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata cyc %0d: got %h want %h", cyc, s_rdata, m_rdata); end
      got_st = {f_count, f_full, f_empty, f_af, f_ae, f_ovr, f_udr};
      n_checks++; if (got_st !== exp_st) begin n_fail++; $display("FAIL rand_fwft_status cyc %0d: got %b want %b", cyc, got_st, exp_st); end
      if (mq.size() > 0) begin
        n_checks++; if (f_rdata !== mq[0]) begin n_fail++; $display("FAIL rand_fwft_rdata cyc %0d: got %h want %h", cyc, f_rdata, mq[0]); end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_order();
    test_overrun_wrap();
    test_underrun();
    test_full_simul();
    test_threshold_comb();
    test_fwft();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
